// File: rtl/fma_dot_sequencer_pkg.sv
// Shared types and defaults for the FMA dot-product sequencer.
// Holds the float word type, the sequencer state encoding and default parameters.
package fma_dot_sequencer_pkg;

  localparam int FMA_SEQ_LEN_W   = 8;
  localparam int FMA_SEQ_TIMEOUT = 16;

  typedef logic [31:0] float_sp;

  localparam float_sp FLOAT_ZERO   = 32'h0000_0000;
  localparam float_sp FAULT_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    SEQ_IDLE    = 4'd0,
    SEQ_FETCH   = 4'd1,
    SEQ_ISSUE_A = 4'd2,
    SEQ_ISSUE_B = 4'd3,
    SEQ_ISSUE_C = 4'd4,
    SEQ_WAIT    = 4'd5,
    SEQ_DONE    = 4'd6,
    SEQ_DRAIN   = 4'd7,
    SEQ_FAULT   = 4'd8
  } fma_seq_state_t;

endpackage

// File: rtl/fma_dot_sequencer_watchdog.sv
// Saturating cycle counter that flags an FMA hang once it has been enabled
// for TIMEOUT consecutive cycles since the last clear.
module fma_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_in,
  input  logic en_in,
  output logic expired_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled and not saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = '0;
    end else if (en_in && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The enabled cycle that sees CNT_LAST is the TIMEOUT-th one.
  assign expired_out = en_in && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/fma_dot_sequencer.sv
// Dot-product sequencer: streams operand pairs into a three-cycle FMA load
// sequence, feeding the running sum back as c, and returns one result per job.
module fma_dot_sequencer
  import fma_dot_sequencer_pkg::*;
#(
  parameter int LEN_W   = FMA_SEQ_LEN_W,
  parameter int TIMEOUT = FMA_SEQ_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [LEN_W-1:0] len_in,
  output logic             busy_out,
  input  logic             op_valid_in,
  output logic             op_ready_out,
  input  logic [31:0]      op_a_in,
  input  logic [31:0]      op_b_in,
  output logic [31:0]      result_out,
  output logic             result_valid_out,
  output logic             error_out,
  output logic             fma_start_out,
  output logic [31:0]      fma_float_out,
  input  logic [31:0]      fma_result_in,
  input  logic             fma_ready_in,
  input  logic             fma_error_in
);

  fma_seq_state_t   state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, pcnt_q, pcnt_d;
  float_sp          a_q, a_d, b_q, b_d, acc_q, acc_d;
  float_sp          result_q, result_d, fma_float_q, fma_float_d;
  logic             result_valid_q, result_valid_d, error_q, error_d;
  logic             fma_start_q, fma_start_d;
  logic             handshake_s, wd_clr_s, wd_en_s, wd_expired_s;

  fma_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clr_in     (wd_clr_s),
    .en_in      (wd_en_s),
    .expired_out(wd_expired_s)
  );

  assign op_ready_out = (state_q == SEQ_FETCH) || (state_q == SEQ_DRAIN);
  assign busy_out     = (state_q != SEQ_IDLE);
  assign handshake_s  = op_valid_in && op_ready_out;

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    wd_clr_s = 1'b0;
    wd_en_s  = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (start_in) begin
          len_d   = len_in;
          acc_d   = FLOAT_ZERO;
          cnt_d   = '0;
          pcnt_d  = '0;
          state_d = (len_in == '0) ? SEQ_DONE : SEQ_FETCH;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_FETCH: begin
        if (handshake_s) begin
          a_d     = op_a_in;
          b_d     = op_b_in;
          pcnt_d  = pcnt_q + LEN_W'(1);
          state_d = SEQ_ISSUE_A;
        end else begin
          state_d = SEQ_FETCH;
        end
      end
      SEQ_ISSUE_A: state_d = SEQ_ISSUE_B;
      SEQ_ISSUE_B: state_d = SEQ_ISSUE_C;
      SEQ_ISSUE_C: begin
        wd_clr_s = 1'b1;
        state_d  = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        wd_en_s = 1'b1;
        // Error beats a simultaneous ready; a job with nothing left to drain faults at once.
        if (fma_error_in || wd_expired_s) begin
          state_d = (pcnt_q == len_q) ? SEQ_FAULT : SEQ_DRAIN;
        end else if (fma_ready_in) begin
          acc_d   = fma_result_in;
          cnt_d   = cnt_q + LEN_W'(1);
          state_d = (cnt_q == len_q - LEN_W'(1)) ? SEQ_DONE : SEQ_FETCH;
        end else begin
          state_d = SEQ_WAIT;
        end
      end
      SEQ_DONE:  state_d = SEQ_IDLE;
      SEQ_DRAIN: begin
        if (handshake_s) begin
          pcnt_d  = pcnt_q + LEN_W'(1);
          state_d = (pcnt_q + LEN_W'(1) == len_q) ? SEQ_FAULT : SEQ_DRAIN;
        end else begin
          state_d = SEQ_DRAIN;
        end
      end
      SEQ_FAULT: state_d = SEQ_IDLE;
      default:   state_d = SEQ_IDLE;
    endcase
  end

  // Registered outputs decoded from the current state; the FMA bus is zero outside issue.
  always_comb begin
    fma_start_d    = (state_q == SEQ_ISSUE_A);
    result_valid_d = (state_q == SEQ_DONE);
    error_d        = (state_q == SEQ_FAULT);
    case (state_q)
      SEQ_ISSUE_A: fma_float_d = a_q;
      SEQ_ISSUE_B: fma_float_d = b_q;
      SEQ_ISSUE_C: fma_float_d = acc_q;
      default:     fma_float_d = FLOAT_ZERO;
    endcase
    if (state_q == SEQ_DONE) begin
      result_d = acc_q;
    end else if (state_q == SEQ_FAULT) begin
      result_d = FAULT_RESULT;
    end else begin
      result_d = result_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= SEQ_IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      pcnt_q         <= '0;
      a_q            <= FLOAT_ZERO;
      b_q            <= FLOAT_ZERO;
      acc_q          <= FLOAT_ZERO;
      result_q       <= FLOAT_ZERO;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      fma_start_q    <= 1'b0;
      fma_float_q    <= FLOAT_ZERO;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      pcnt_q         <= pcnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
      fma_start_q    <= fma_start_d;
      fma_float_q    <= fma_float_d;
    end
  end

  assign result_out       = result_q;
  assign result_valid_out = result_valid_q;
  assign error_out        = error_q;
  assign fma_start_out    = fma_start_q;
  assign fma_float_out    = fma_float_q;

endmodule

// File: doc/fma_dot_sequencer.md
# fma_dot_sequencer

Controller that sequences the single-precision `fma` datapath to compute a dot product, sum(a[i]*b[i]) for i = 0..len-1, from a streamed operand-pair interface. It owns the FMA's `start_in`/`float_in` bus. It serialises each pair into the FMA's three-cycle a/b/c load sequence, feeding the running accumulator back as c. It waits on `ready_out`/`error_out` and returns one result per job. It sits between the MPU operand fetch logic and one `fma` instance.

## Interface
- `LEN_W`, 8: width of the job length; max len = 2^LEN_W-1.
- `TIMEOUT`, 16: max cycles in WAIT before declaring an FMA hang.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start_in` in 1: begin a job; sampled only in IDLE.
- `len_in` in LEN_W: number of operand pairs; sampled with `start_in`.
- `busy_out` out 1: high in every state except IDLE.
- `op_valid_in` in 1: operand pair available.
- `op_ready_out` out 1: pair accepted when `op_valid_in && op_ready_out`.
- `op_a_in`, `op_b_in` in 32 (float_sp): operand pair.
- `result_out` out 32 (float_sp): dot product; held until next job.
- `result_valid_out` out 1: one-cycle pulse.
- `error_out` out 1: one-cycle pulse at job abort.
- `fma_start_out` out 1: to `fma.start_in`.
- `fma_float_out` out 32: to `fma.float_in`.
- `fma_result_in` in 32: from `fma.float_out`.
- `fma_ready_in` in 1: from `fma.ready_out`.
- `fma_error_in` in 1: from `fma.error_out`.

## Operation
- **Reset** (`rst`=0, immediate): state IDLE. All outputs are 0, including `result_out`=0 and `fma_float_out`=0. Accumulator and counters are 0.
- **States:** IDLE, FETCH, ISSUE_A, ISSUE_B, ISSUE_C, WAIT, DONE, DRAIN, FAULT.
- **IDLE:**
  - On `start_in`: latch len and set acc=0, cnt=0.
  - If len==0, go to DONE. Otherwise go to FETCH.
- **FETCH:**
  - `op_ready_out`=1.
  - On handshake: latch a and b, go to ISSUE_A.
  - With no valid pair, stay in FETCH.
- **ISSUE_A:** `fma_start_out`=1, `fma_float_out`=a.
- **ISSUE_B:** `fma_float_out`=b.
- **ISSUE_C:** `fma_float_out`=acc; clear the watchdog.
- **WAIT:**
  - `fma_error_in`, or watchdog reaching TIMEOUT: go to DRAIN.
  - Else `fma_ready_in`: acc <= `fma_result_in`, cnt++. If cnt==len-1 go to DONE, else go to FETCH.
  - If ready and error are high together, error wins.
- **DONE:** `result_out`=acc, `result_valid_out`=1 for one cycle, go to IDLE.
- **DRAIN:**
  - `op_ready_out`=1; accept and discard pairs until len pairs have been consumed in total for the job.
  - Then go to FAULT. If all pairs are already consumed, go to FAULT directly.
- **FAULT:** `error_out`=1 for one cycle, `result_out`=32'hFFFFFFFF, go to IDLE.
- **FMA bus when idle:**
  - Outside ISSUE_A/B/C, `fma_start_out`=0 and `fma_float_out`=0.
  - Zero is required because the FMA flags errors on any non-zero denormal, Inf or NaN on its bus even while idle.
- **Operand checks:** no range or NaN checking on operands; the FMA detects them and the sequencer reacts via `fma_error_in`.
- **Start while busy:** `start_in` outside IDLE is ignored.

## Timing
- **Issue alignment:** ISSUE_A, ISSUE_B and ISSUE_C occupy consecutive cycles. They align with the FMA latching a in IDLE, b in LOAD and c in MULTIPLY.
- **Per-element latency:** 1 (FETCH, zero-wait upstream) + 3 (issue) + WAIT. WAIT is 4–6 cycles depending on whether the FMA skips ACCUMULATE/NORMALIZE.
- **First element:** c=0, so the FMA skips ACCUMULATE/NORMALIZE.
- **len==0:** `result_valid_out` is high 2 cycles after the `start_in` edge, with `result_out`=0.
- **`op_ready_out`:** high only in FETCH and DRAIN; combinational from state only, never from `op_valid_in`.
- **Outputs:** all outputs are registered, except `op_ready_out` and `busy_out`, which are decoded from state.
- **Reset mid-job:** reset during any state aborts silently with no `error_out` pulse. The FMA is reset from the same source; the top level inverts `rst` into the FMA's active-high `rst`.

## Structure
- **`mpu_data_types`:** add the `fma_seq_state_t` enum; reuse `float_sp`.
- **`global_defs`:** add `FMA_SEQ_LEN_W` and `FMA_SEQ_TIMEOUT` as defaults.
- **Sub-module `fma_watchdog`:**
  - Saturating counter with `clr_in`, `en_in` and `expired_out`, parameterised by TIMEOUT.
  - The sequencer instantiates one.
- **FMA instance:** instantiated at MPU level, not inside the sequencer.

## Test plan
- **Single pair:** len=1, a=0x40000000 (2.0), b=0x40400000 (3.0) -> `result_out`=0x40C00000, one `result_valid_out` pulse, `fma_start_out` asserted exactly once.
- **Three pairs:** len=3, pairs (1.0,2.0), (3.0,4.0), (0.5,4.0) -> 0x41800000 (16.0). The c value driven in each ISSUE_C equals the previous `fma_result_in`.
- **Zero length:** len=0 -> 0x00000000 valid 2 cycles after start; `op_ready_out` and `fma_start_out` never high.
- **Backpressure:** `op_valid_in` low for 5 cycles between pairs -> sequencer holds FETCH, `fma_float_out`=0 throughout, result still correct.
- **FMA error:** len=4, pair 2 a=0x7F800000 (Inf) -> `fma_error_in` -> remaining 2 pairs accepted and discarded, then `error_out` pulse, `result_out`=0xFFFFFFFF, no `result_valid_out`.
- **Hang and reset:**
  - With `fma_ready_in` tied 0, `error_out` fires after TIMEOUT WAIT cycles.
  - Separately, `rst` low mid-WAIT -> all outputs 0 asynchronously. A new start after release completes normally.
